// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_pkg                                                  |
// | Brief   : Op encodings and width helpers shared by the shift unit.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // Ceiling log2; exact for the power-of-two widths this unit supports.
    function automatic int shift_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int SHIFT_DEFAULT_WIDTH = 32;
    localparam int SHIFT_DEFAULT_LOG2  = shift_log2(SHIFT_DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_stage                                                |
// | Brief   : Combinational barrel group for amount bits [HI:LO].        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LO        = 0,
    parameter int HI        = 1,
    parameter bit APPLY_OVR = 1'b0
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic [HI-LO:0]   amt,
    input  logic             ovr,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] w_acc;
    int               w_n;

    always_comb begin
        w_acc = data_in;
        w_n   = 0;
        for (int k = 0; k <= HI - LO; k++) begin
            if (amt[k]) begin
                w_n = 1 << (k + LO);
                case (op)
                    OP_SHL:  w_acc = w_acc << w_n;
                    OP_SHR:  w_acc = w_acc >> w_n;
                    OP_SRA:  w_acc = $signed(w_acc) >>> w_n;
                    OP_ROL:  w_acc = (w_acc << w_n) | (w_acc >> (WIDTH - w_n));
                    OP_ROR:  w_acc = (w_acc >> w_n) | (w_acc << (WIDTH - w_n));
                    default: w_acc = w_acc;
                endcase
            end
        end
        // Over-range shifts saturate; SRA keeps the sign, which earlier steps preserved.
        if (APPLY_OVR && ovr) begin
            case (op)
                OP_SHL, OP_SHR: w_acc = '0;
                OP_SRA:         w_acc = {WIDTH{w_acc[WIDTH-1]}};
                default:        w_acc = w_acc;
            endcase
        end
        data_out = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_unit                                                 |
// | Brief   : Two-stage pipelined shifter/rotator with valid/ready.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic [AMT_W-1:0] sh_amount,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_zero
);

    localparam int S    = shift_log2(WIDTH);
    localparam int S_LO = S / 2;
    localparam int S_HI = S - S_LO;

    logic             w_ovr;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_stage1_out;
    logic [WIDTH-1:0] w_stage2_out;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic [S_HI-1:0]  s1_amt_q,   s1_amt_d;
    logic             s1_ovr_q,   s1_ovr_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_zero_q,  out_zero_d;

    generate
        if (AMT_W > S) begin : g_ovr
            assign w_ovr = |sh_amount[AMT_W-1:S];
        end else begin : g_no_ovr
            assign w_ovr = 1'b0;
        end
    endgenerate

    assign w_s2_adv = !s2_valid_q || out_ready;
    assign w_s1_adv = !s1_valid_q || w_s2_adv;
    assign in_ready = w_s1_adv;

    shift_stage #(
        .WIDTH     (WIDTH),
        .LO        (0),
        .HI        (S_LO - 1),
        .APPLY_OVR (1'b0)
    ) u_stage1 (
        .data_in  (in_value),
        .op       (op),
        .amt      (sh_amount[S_LO-1:0]),
        .ovr      (1'b0),
        .data_out (w_stage1_out)
    );

    shift_stage #(
        .WIDTH     (WIDTH),
        .LO        (S_LO),
        .HI        (S - 1),
        .APPLY_OVR (1'b1)
    ) u_stage2 (
        .data_in  (s1_data_q),
        .op       (s1_op_q),
        .amt      (s1_amt_q),
        .ovr      (s1_ovr_q),
        .data_out (w_stage2_out)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_op_d     = s1_op_q;
        s1_amt_d    = s1_amt_q;
        s1_ovr_d    = s1_ovr_q;
        s2_valid_d  = s2_valid_q;
        out_value_d = out_value_q;
        out_zero_d  = out_zero_q;

        if (w_s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = w_stage1_out;
                s1_op_d   = op;
                s1_amt_d  = sh_amount[S-1:S_LO];
                s1_ovr_d  = w_ovr;
            end
        end

        // The output register only changes when a real result moves in, so it holds while stalled.
        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_value_d = w_stage2_out;
                out_zero_d  = (w_stage2_out == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= '0;
            s1_amt_q    <= '0;
            s1_ovr_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_value_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_op_q     <= s1_op_d;
            s1_amt_q    <= s1_amt_d;
            s1_ovr_q    <= s1_ovr_d;
            s2_valid_q  <= s2_valid_d;
            out_value_q <= out_value_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_value = out_value_q;
    assign out_zero  = out_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_shift_unit                                              |
// | Brief   : Directed self-checking bench for shift_unit (WIDTH=32).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int AMT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_value = '0;
    logic [AMT_W-1:0] sh_amount = '0;
    logic [2:0]       op = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_value;
    logic             out_zero;

    int checks = 0;
    int errors = 0;

    shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .sh_amount (sh_amount),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 one cycle after the result appears.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] v,
                          input logic [31:0] a, input logic [31:0] exp);
        op = o; in_value = v; sh_amount = a; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid_c1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({tag, "_valid_c2"}, 64'(out_valid), 64'(1));
        check({tag, "_value"}, 64'(out_value), 64'(exp));
        check({tag, "_zero"}, 64'(out_zero), 64'(exp == 32'd0));
        @(posedge clk); #1;
    endtask

    logic [31:0] exp_q [8];
    logic [31:0] held;
    int          sent, recv, occ;
    logic        stalled, saw_in_ready_low, in_x, out_x;

    initial begin
        #2 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_value", 64'(out_value), 64'(0));
        check("rst_out_zero",  64'(out_zero),  64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op("shl_1_by_3",   3'd0, 32'h0000_0001, 32'd3,   32'h0000_0008);
        run_op("sra_by_4",     3'd2, 32'h8000_0000, 32'd4,   32'hF800_0000);
        run_op("shr_by_4",     3'd1, 32'h8000_0000, 32'd4,   32'h0800_0000);
        run_op("sra_by_40",    3'd2, 32'h8000_0000, 32'd40,  32'hFFFF_FFFF);
        run_op("shl_by_32",    3'd0, 32'hFFFF_FFFF, 32'd32,  32'h0000_0000);
        run_op("rol_by_1",     3'd3, 32'h8000_0001, 32'd1,   32'h0000_0003);
        run_op("ror_by_33",    3'd4, 32'h0000_0001, 32'd33,  32'h8000_0000);
        run_op("op6_pass",     3'd6, 32'h1234_5678, 32'd5,   32'h1234_5678);
        run_op("sra_by_0",     3'd2, 32'h8000_0000, 32'd0,   32'h8000_0000);
        run_op("shr_by_31",    3'd1, 32'hFFFF_FFFF, 32'd31,  32'h0000_0001);
        run_op("rol_by_36",    3'd3, 32'h1234_5678, 32'd36,  32'h2345_6781);
        run_op("sra_pos_100",  3'd2, 32'h4000_0000, 32'd100, 32'h0000_0000);
        run_op("ror_by_0",     3'd4, 32'hA5A5_0F0F, 32'd0,   32'hA5A5_0F0F);

        // Back-to-back stream of 8 SHLs with a 4-cycle consumer stall.
        for (int i = 0; i < 8; i++) exp_q[i] = 32'h0000_0003 << i;
        sent = 0; recv = 0; occ = 0; stalled = 1'b0; saw_in_ready_low = 1'b0; held = '0;
        for (int c = 0; c < 30; c++) begin
            in_valid  = (sent < 8);
            op        = 3'd0;
            in_value  = 32'h0000_0003;
            sh_amount = 32'(sent);
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'((occ == 2) ? out_ready : 1'b1));
            if (!in_ready) saw_in_ready_low = 1'b1;
            if (stalled) begin
                check("stall_valid_hold", 64'(out_valid), 64'(1));
                check("stall_value_hold", 64'(out_value), 64'(held));
            end
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                if (recv < 8) check("stream_result", 64'(out_value), 64'(exp_q[recv]));
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = out_value;
            if (in_x) sent++;
            occ = occ + int'(in_x) - int'(out_x);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stream_sent",          64'(sent), 64'(8));
        check("stream_recv",          64'(recv), 64'(8));
        check("stream_in_ready_drop", 64'(saw_in_ready_low), 64'(1));

        // Two operands in flight, then an asynchronous mid-cycle reset.
        out_ready = 1'b0; op = 3'd0; in_value = 32'h0000_0011; sh_amount = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_value = 32'h0000_0022;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("prerst_out_valid", 64'(out_valid), 64'(1));
        check("prerst_out_value", 64'(out_value), 64'(32'h0000_0022));
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_value", 64'(out_value), 64'(0));
        check("arst_out_zero",  64'(out_zero),  64'(0));
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready",  64'(in_ready),  64'(1));
        check("postrst_valid_c1",  64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("postrst_valid_c2",  64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("postrst_valid_c3",  64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
